// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: register word/index types and the writeback result-select encoding.
package cpu_pkg;

  typedef logic [15:0] word_t;
  typedef logic [3:0]  reg_idx_t;

  typedef enum logic [1:0] {
    RES_ALU   = 2'b00,
    RES_MEM   = 2'b01,
    RES_PC2   = 2'b10,
    RES_WDATA = 2'b11
  } result_src_e;

  localparam reg_idx_t REG_ZERO = 4'd0;

endpackage

// File: rtl/wb_result_mux.sv
// Writeback result select: purely combinational 4:1 mux, zero latency, no flow control.
module wb_result_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  result_src_e       i_sel,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_pc2,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    o_result = i_wdata;
    case (i_sel)
      RES_ALU: o_result = i_alu;
      RES_MEM: o_result = i_mem;
      RES_PC2: o_result = i_pc2;
      default: o_result = i_wdata;
    endcase
  end

endmodule

// File: rtl/wb_regfile_unit.sv
// MEM/WB writeback stage: result select, register file commit with write-first read bypass,
// registered debug read port (no bypass) and a wrapping writeback-event counter.
module wb_regfile_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite_in,
  input  logic [1:0]        resultSrc_in,
  input  logic [DATA_W-1:0] pc_plus2_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic [DATA_W-1:0] aluRes_in,
  input  logic [DATA_W-1:0] readData_in,
  input  logic [DATA_W-1:0] writeDataW_in,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] result_out,
  output logic              wb_en_out,
  output logic [ADDR_W-1:0] wb_rd_out,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wb_count
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_dbg;
  logic [DATA_W-1:0] w_result;
  logic              w_wb_en;

  wb_result_mux #(.DATA_W(DATA_W)) u_mux (
    .i_sel    (result_src_e'(resultSrc_in)),
    .i_alu    (aluRes_in),
    .i_mem    (readData_in),
    .i_pc2    (pc_plus2_in),
    .i_wdata  (writeDataW_in),
    .o_result (w_result)
  );

  // r0 writes are dropped here so they neither commit nor count
  assign w_wb_en    = regWrite_in && (rd_in != REG_ZERO);
  assign wb_en_out  = w_wb_en;
  assign wb_rd_out  = rd_in;
  assign result_out = w_result;

  always_comb begin
    rd1 = r_regs[ra1];
    if (ra1 == REG_ZERO)                    rd1 = '0;
    else if (w_wb_en && (ra1 == rd_in))     rd1 = w_result;
  end

  always_comb begin
    rd2 = r_regs[ra2];
    if (ra2 == REG_ZERO)                    rd2 = '0;
    else if (w_wb_en && (ra2 == rd_in))     rd2 = w_result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[rd_in] <= w_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_cnt <= '0;
    else if (w_wb_en) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Debug port samples the array before this edge's write lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_dbg <= '0;
    else if (dbg_addr == REG_ZERO)  r_dbg <= '0;
    else                            r_dbg <= r_regs[dbg_addr];
  end

  assign wb_count = r_cnt;
  assign dbg_data = r_dbg;

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed self-checking bench for wb_regfile_unit, built with a 4-bit counter to exercise wrap.
module tb_wb_regfile_unit;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          regWrite_in;
  logic [1:0]    resultSrc_in;
  logic [DW-1:0] pc_plus2_in, aluRes_in, readData_in, writeDataW_in;
  logic [AW-1:0] rd_in, ra1, ra2, dbg_addr;
  logic [DW-1:0] rd1, rd2, result_out, dbg_data;
  logic          wb_en_out;
  logic [AW-1:0] wb_rd_out;
  logic [CW-1:0] wb_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_regfile_unit #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .regWrite_in(regWrite_in), .resultSrc_in(resultSrc_in),
    .pc_plus2_in(pc_plus2_in), .rd_in(rd_in), .aluRes_in(aluRes_in),
    .readData_in(readData_in), .writeDataW_in(writeDataW_in), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .result_out(result_out), .wb_en_out(wb_en_out),
    .wb_rd_out(wb_rd_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wb_count(wb_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rw;
    logic [1:0]    src;
    logic [AW-1:0] rd;
    logic [DW-1:0] alu;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] e_rd1;
    logic [DW-1:0] e_rd2;
    logic [DW-1:0] e_res;
    logic          e_en;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b1, 2'd0, 4'd3, 16'hBEEF, 4'd3, 4'd0, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b1, 4'd0};
    vecs[1]  = '{1'b0, 2'd0, 4'd0, 16'h0000, 4'd0, 4'd3, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 4'd1};
    vecs[2]  = '{1'b1, 2'd0, 4'd0, 16'h1234, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h1234, 1'b0, 4'd1};
    vecs[3]  = '{1'b1, 2'd0, 4'd5, 16'h1111, 4'd5, 4'd3, 16'h1111, 16'hBEEF, 16'h1111, 1'b1, 4'd1};
    vecs[4]  = '{1'b1, 2'd1, 4'd6, 16'h1111, 4'd6, 4'd3, 16'h2222, 16'hBEEF, 16'h2222, 1'b1, 4'd2};
    vecs[5]  = '{1'b1, 2'd2, 4'd7, 16'h1111, 4'd7, 4'd3, 16'h3333, 16'hBEEF, 16'h3333, 1'b1, 4'd3};
    vecs[6]  = '{1'b1, 2'd3, 4'd8, 16'h1111, 4'd8, 4'd3, 16'h4444, 16'hBEEF, 16'h4444, 1'b1, 4'd4};
    vecs[7]  = '{1'b0, 2'd2, 4'd0, 16'h1111, 4'd5, 4'd6, 16'h1111, 16'h2222, 16'h3333, 1'b0, 4'd5};
    vecs[8]  = '{1'b0, 2'd2, 4'd0, 16'h1111, 4'd7, 4'd8, 16'h3333, 16'h4444, 16'h3333, 1'b0, 4'd5};
    vecs[9]  = '{1'b1, 2'd0, 4'd5, 16'h7777, 4'd5, 4'd5, 16'h7777, 16'h7777, 16'h7777, 1'b1, 4'd5};
    vecs[10] = '{1'b0, 2'd0, 4'd0, 16'h0000, 4'd5, 4'd0, 16'h7777, 16'h0000, 16'h0000, 1'b0, 4'd6};

    reset = 1'b1; regWrite_in = 1'b0; resultSrc_in = 2'd0; rd_in = '0;
    aluRes_in = '0; readData_in = 16'h2222; pc_plus2_in = 16'h3333; writeDataW_in = 16'h4444;
    ra1 = '0; ra2 = '0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Reset state: every register reads zero on both ports
    for (int a = 0; a < 16; a++) begin
      ra1 = AW'(a); ra2 = AW'(15 - a);
      #1;
      chk("reset_rd1", 32'(rd1), 32'h0);
      chk("reset_rd2", 32'(rd2), 32'h0);
    end
    chk("reset_cnt", 32'(wb_count), 32'h0);
    chk("reset_dbg", 32'(dbg_data), 32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      regWrite_in = vecs[i].rw; resultSrc_in = vecs[i].src; rd_in = vecs[i].rd;
      aluRes_in = vecs[i].alu; ra1 = vecs[i].a1; ra2 = vecs[i].a2;
      #1;
      chk("vec_rd1",    32'(rd1),        32'(vecs[i].e_rd1));
      chk("vec_rd2",    32'(rd2),        32'(vecs[i].e_rd2));
      chk("vec_result", 32'(result_out), 32'(vecs[i].e_res));
      chk("vec_wb_en",  32'(wb_en_out),  32'(vecs[i].e_en));
      chk("vec_wb_rd",  32'(wb_rd_out),  32'(vecs[i].rd));
      chk("vec_cnt",    32'(wb_count),   32'(vecs[i].e_cnt));
    end

    // Debug port returns pre-write contents, then the new value a cycle later
    @(negedge clk);
    regWrite_in = 1'b1; resultSrc_in = 2'd0; rd_in = 4'd5; aluRes_in = 16'hCAFE; dbg_addr = 4'd5;
    @(posedge clk); #1;
    chk("dbg_no_bypass", 32'(dbg_data), 32'h7777);
    @(negedge clk); regWrite_in = 1'b0;
    @(posedge clk); #1;
    chk("dbg_after", 32'(dbg_data), 32'hCAFE);
    chk("cnt_7", 32'(wb_count), 32'd7);
    @(negedge clk); dbg_addr = 4'd0;
    @(posedge clk); #1;
    chk("dbg_r0", 32'(dbg_data), 32'h0);

    // Counter wrap at 4 bits: 7 + 8 = 15, one more wraps to 0
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      regWrite_in = 1'b1; rd_in = 4'd10; aluRes_in = DW'(i);
    end
    @(negedge clk); regWrite_in = 1'b0; #1;
    chk("cnt_15", 32'(wb_count), 32'd15);
    @(negedge clk); regWrite_in = 1'b1; aluRes_in = 16'h00AA;
    @(negedge clk); regWrite_in = 1'b0; #1;
    chk("cnt_wrap", 32'(wb_count), 32'd0);

    // Unknown select with write disabled must leave state intact
    @(negedge clk); resultSrc_in = 2'bxx; ra1 = 4'd10;
    @(negedge clk); resultSrc_in = 2'd0; #1;
    chk("x_src_r10", 32'(rd1), 32'h00AA);
    chk("x_src_cnt", 32'(wb_count), 32'd0);

    // Reset landing during an in-flight write
    @(negedge clk);
    regWrite_in = 1'b1; rd_in = 4'd9; aluRes_in = 16'hA5A5; dbg_addr = 4'd9;
    @(negedge clk); regWrite_in = 1'b0;
    @(posedge clk); #1;
    chk("r9_dbg", 32'(dbg_data), 32'hA5A5);
    chk("r9_cnt", 32'(wb_count), 32'd1);
    @(negedge clk);
    regWrite_in = 1'b1; rd_in = 4'd9; aluRes_in = 16'h5A5A;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_cnt", 32'(wb_count), 32'd0);
    chk("rst_async_dbg", 32'(dbg_data), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0; regWrite_in = 1'b0; ra1 = 4'd9; #1;
    chk("rst_r9", 32'(rd1), 32'h0);
    chk("rst_cnt", 32'(wb_count), 32'd0);
    chk("rst_dbg", 32'(dbg_data), 32'h0);
    @(posedge clk); #1;
    chk("rst_dbg_r9", 32'(dbg_data), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
